// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  // Unsigned loads have no store counterpart.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response channel plus data-memory port of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/lsu_align.sv
// Lane logic: extracts and extends load data, merges sub-word store data
// into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load lane select and sign/zero extension.
  always_comb begin
    byte_s    = rd_word[{byte_off, 3'b000} +: 8];
    half_s    = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'h00_0000, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'h0000, half_s};
      F3_W:    load_data = rd_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: only the addressed lanes take the new data.
  always_comb begin
    store_word = merge_word;
    case (funct3)
      F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_off[1]) begin
          store_word[31:16] = wdata[15:0];
        end else begin
          store_word[15:0] = wdata[15:0];
        end
      end
      F3_W:    store_word = wdata;
      default: store_word = merge_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sub-word stores done as
// read-modify-write against a single-port word memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 101
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e  state_r, state_next_s;
  logic [31:0] addr_r, wdata_r, merge_r, rdata_r;
  logic [2:0]  funct3_r;
  logic        err_r;
  logic        accept_s, err_s, misalign_s, range_s;
  logic [31:0] word_idx_s, load_data_s, store_word_s;

  assign accept_s   = bus.req_valid && (state_r == IDLE);
  assign word_idx_s = {2'b00, bus.req_addr[31:2]};
  assign range_s    = (word_idx_s >= 32'(MEM_WORDS));
  assign misalign_s = (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0])
                    || ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
  assign err_s      = !f3_legal(bus.req_funct3, bus.req_we) || misalign_s || range_s;

  lsu_align u_align (
    .funct3     (funct3_r),
    .byte_off   (addr_r[1:0]),
    .rd_word    (bus.mem_RD),
    .merge_word (merge_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .store_word (store_word_s)
  );

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_next_s = IDLE;
        end else if (err_s) begin
          state_next_s = RESP;
        end else if (!bus.req_we) begin
          state_next_s = LOAD;
        end else if (bus.req_funct3 == F3_W) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = RMW_RD;
        end
      end
      LOAD:    state_next_s = RESP;
      RMW_RD:  state_next_s = WRITE;
      WRITE:   state_next_s = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, merge buffer and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      funct3_r <= 3'b000;
      merge_r  <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            funct3_r <= bus.req_funct3;
            err_r    <= err_s;
            rdata_r  <= 32'h0000_0000;
          end
        end
        LOAD:    rdata_r <= load_data_s;
        RMW_RD:  merge_r <= bus.mem_RD;
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = (state_r == RESP);
  assign bus.resp_rdata = rdata_r;
  assign bus.resp_err   = err_r;
  assign bus.mem_A      = {addr_r[31:2], 2'b00};
  assign bus.mem_WD     = store_word_s;
  // Reset kills a write already sitting in WRITE on the same edge.
  assign bus.mem_WE     = (state_r == WRITE) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// random traffic compared against a byte-lane arithmetic reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 101;

  logic clk = 1'b0;
  logic rst;
  logic load_init;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem      [MEM_WORDS];
  logic [31:0] init_img [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  int errors = 0;
  int checks = 0;

  always_comb begin
    int w;
    w = int'(bus.mem_A >> 2);
    if (w < MEM_WORDS) bus.mem_RD = mem[w];
    else               bus.mem_RD = 32'h0000_0000;
  end

  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_img[i];
    end else if (bus.mem_WE && (int'(bus.mem_A >> 2) < MEM_WORDS)) begin
      mem[int'(bus.mem_A >> 2)] <= bus.mem_WD;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                                output logic [31:0] new_word, output int lat);
    int size, off;
    bit legal;
    logic [31:0] w, mask;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    off   = int'(addr % 4);
    err   = !legal || ((addr % size) != 0) || ((addr >> 2) >= MEM_WORDS);
    rdata = 32'h0000_0000;
    new_word = 32'h0000_0000;
    lat   = 1;
    if (!err) begin
      w = ref_mem[int'(addr >> 2)];
      if (!we) begin
        lat   = 2;
        rdata = w >> (8 * off);
        if (size == 1) begin
          rdata = rdata & 32'h0000_00FF;
          if (f3 == 3'd0 && rdata[7]) rdata = rdata | 32'hFFFF_FF00;
        end else if (size == 2) begin
          rdata = rdata & 32'h0000_FFFF;
          if (f3 == 3'd1 && rdata[15]) rdata = rdata | 32'hFFFF_0000;
        end
      end else begin
        lat  = (size == 4) ? 2 : 3;
        mask = (size == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * size)) - 32'h1) << (8 * off));
        new_word = (w & ~mask) | ((wd << (8 * off)) & mask);
      end
    end
  endfunction

  task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold, input string tag);
    logic exp_err;
    logic [31:0] exp_rd, exp_word, wd_seen, a_seen, rd_held;
    int exp_lat, cyc, we_cnt, waitc;
    model(we, f3, addr, wd, exp_err, exp_rd, exp_word, exp_lat);
    wd_seen = 32'h0; a_seen = 32'h0;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    check({tag, " ready_before"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd; bus.resp_ready = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 0; we_cnt = 0;
    do begin
      @(negedge clk); cyc++;
      if (bus.mem_WE) begin we_cnt++; wd_seen = bus.mem_WD; a_seen = bus.mem_A; end
    end while (!bus.resp_valid && cyc < 20);
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, " rdata"}, bus.resp_rdata, exp_rd);
    check({tag, " we_pulses"}, 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) begin
      check({tag, " mem_WD"}, wd_seen, exp_word);
      check({tag, " mem_A"}, a_seen, {addr[31:2], 2'b00});
      ref_mem[int'(addr >> 2)] = exp_word;
    end
    rd_held = bus.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, " hold_rdata"}, bus.resp_rdata, rd_held);
      check({tag, " hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check({tag, " ready_after"}, 32'(bus.req_ready), 32'd1);
    check({tag, " valid_after"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] a;
    for (int i = 0; i < MEM_WORDS; i++) begin
      init_img[i] = $urandom;
      ref_mem[i]  = init_img[i];
    end
    init_img[3] = 32'h8899_AABB; ref_mem[3] = 32'h8899_AABB;
    rst = 1'b1; load_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("we_in_reset", 32'(bus.mem_WE), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; load_init = 1'b0;
    @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_err", 32'(bus.resp_err), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'h0);
    check("rst mem_A", bus.mem_A, 32'h0);
    check("rst mem_WD", bus.mem_WD, 32'h0);
    check("rst mem_WE", 32'(bus.mem_WE), 32'd0);

    transact(1'b0, F3_B,  32'h0000_000D, 32'h0, 0, "lb_0d");
    transact(1'b1, F3_H,  32'h0000_000E, 32'h0000_1234, 0, "sh_0e");
    check("word3_after_sh", mem[3], 32'h1234_AABB);
    transact(1'b0, F3_HU, 32'h0000_000E, 32'h0, 0, "lhu_0e");
    transact(1'b0, F3_W,  32'h0000_0006, 32'h0, 0, "lw_misalign");
    transact(1'b1, F3_W,  32'(4 * MEM_WORDS), 32'hDEAD_BEEF, 0, "sw_range");
    compare_mem("mem_after_range");
    transact(1'b0, F3_W,  32'h0000_000C, 32'h0, 5, "lw_hold");
    transact(1'b1, F3_BU, 32'h0000_0010, 32'h55, 0, "sbu_illegal");

    // Reset while the store sits in WRITE.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h0000_0001; bus.req_wdata = 32'h0000_00C3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw in_write", 32'(bus.mem_WE), 32'd1);
    rst = 1'b1; #1;
    check("rstw we_gated", 32'(bus.mem_WE), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw req_ready", 32'(bus.req_ready), 32'd1);
    check("rstw word0", mem[0], ref_mem[0]);
    check("rstw mem_A", bus.mem_A, 32'h0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.resp_valid) seen++; end
    check("rstw no_resp", 32'(seen), 32'd0);

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, MEM_WORDS + 2)) * 32'd4 + 32'($urandom_range(0, 3));
      transact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "rand");
    end
    compare_mem("mem_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
